mem_port_sched: RTL and testbench

Sequencer and arbiter for the data port of the dual-port instruction/data RAM. It shares one synchronous RAM port between the CPU load/store unit and the UART program loader. It also turns byte and halfword stores into read-modify-write sequences, which replaces the free-running write-strobe counter. It sits between the MEM stage / loader and the RAM data port; MMIO decoding (addr[31:16] == 16'hffff) happens upstream, so only RAM addresses reach this block.

---
 rtl/mem_port_sched.sv | 165 ++++++++++++++++
 tb/tb_mem_port_sched.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// RAM data-port sequencer: round-robin arbitration between the CPU load/store
// unit and the UART loader, load formatting, and read-modify-write sub-word stores.
module mem_port_sched #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_misalign,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    // Handshake: a requester raises req with its fields and holds them until a
    // one-cycle ack; a req still high in the IDLE cycle after ack is a new request.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;

    state_t      state;
    logic        last_grant;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic        grant_cpu;
    logic        grant_ld;
    logic        cpu_misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;
    logic [31:0] merged;
    logic        unused_bits;

    // Tie goes to whoever was not granted last.
    assign grant_cpu = cpu_req && (!ld_req || (last_grant == GRANT_LD));
    assign grant_ld  = ld_req && !grant_cpu;

    assign cpu_misaligned = ((cpu_size == 2'd1) && cpu_addr[0]) ||
                            (cpu_size[1] && (cpu_addr[1:0] != 2'b00));

    assign busy        = (state != IDLE);
    assign dbg_state   = state;
    assign unused_bits = ^{cpu_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GRANT_LD;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            wdata_q      <= 32'd0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_misalign <= 1'b0;
            ld_ack       <= 1'b0;
        end else begin
            cpu_ack      <= 1'b0;
            cpu_misalign <= 1'b0;
            ld_ack       <= 1'b0;
            ram_we       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ld) begin
                        last_grant <= GRANT_LD;
                        we_q       <= 1'b1;
                        uns_q      <= 1'b0;
                        size_q     <= 2'd2;
                        off_q      <= 2'd0;
                        wdata_q    <= ld_wdata;
                        ram_addr   <= ld_addr[ADDR_W+1:2];
                        ram_we     <= 1'b1;
                        ld_ack     <= 1'b1;
                        state      <= WR;
                    end else if (grant_cpu) begin
                        last_grant <= GRANT_CPU;
                        we_q       <= cpu_we;
                        uns_q      <= cpu_unsigned;
                        size_q     <= cpu_size[1] ? 2'd2 : cpu_size;
                        off_q      <= cpu_addr[1:0];
                        wdata_q    <= cpu_wdata;
                        ram_addr   <= cpu_addr[ADDR_W+1:2];
                        if (cpu_misaligned) begin
                            cpu_ack      <= 1'b1;
                            cpu_misalign <= 1'b1;
                            state        <= ERR;
                        end else if (cpu_we && cpu_size[1]) begin
                            ram_we  <= 1'b1;
                            cpu_ack <= 1'b1;
                            state   <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                // Only CPU loads and sub-word stores pass through RD.
                RD: begin
                    cpu_ack <= 1'b1;
                    ram_we  <= we_q;
                    state   <= MERGE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_byte = ram_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        rd_fmt  = ram_rdata;
        merged  = ram_rdata;
        case (size_q)
            2'd0: begin
                rd_fmt = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'd1: begin
                rd_fmt = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                rd_fmt = ram_rdata;
                merged = wdata_q;
            end
        endcase

        cpu_rdata = 32'd0;
        if (state == MERGE && !we_q) begin
            cpu_rdata = rd_fmt;
        end

        ram_wdata = 32'd0;
        if (ram_we) begin
            ram_wdata = (state == MERGE) ? merged : wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: behavioural RAM, word-level reference memory,
// scoreboard queue popped by a monitor on every ack.
module tb_mem_port_sched;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [1:0]    cpu_size = 2'd0;
    logic          cpu_unsigned = 1'b0;
    logic [31:0]   cpu_addr = 32'd0;
    logic [31:0]   cpu_wdata = 32'd0;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;
    logic          cpu_misalign;
    logic          ld_req = 1'b0;
    logic [31:0]   ld_addr = 32'd0;
    logic [31:0]   ld_wdata = 32'd0;
    logic          ld_ack;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic          busy;
    logic [2:0]    dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int cpu_ack_cyc = 0;
    int ld_ack_cyc = 0;
    int ld_pending = 0;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic        exp_mis_q [$];

    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_idx = '0;
    logic [31:0]   bd_data = 32'd0;

    mem_port_sched #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_misalign(cpu_misalign),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_word(input int idx, input logic [31:0] v);
        bd_we   = 1'b1;
        bd_idx  = idx[AW-1:0];
        bd_data = v;
        ref_mem[idx] = v;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata, input bit chk);
        int idx, off, sz, sh, lat;
        logic mis;
        logic [31:0] w, v, mask;
        bit got;
        idx = int'(addr[AW+1:2]);
        off = int'(addr[1:0]);
        sz  = (size == 2'd3) ? 2 : int'(size);
        mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
        sh  = (sz == 0) ? 8 * off : (sz == 1) ? 16 * (off / 2) : 0;
        w   = ref_mem[idx];
        v   = 32'd0;
        if (!mis && !we) begin
            if (sz == 0) begin
                v = (w >> sh) & 32'h0000_00ff;
                if (!uns && v[7]) v = v | 32'hffff_ff00;
            end else if (sz == 1) begin
                v = (w >> sh) & 32'h0000_ffff;
                if (!uns && v[15]) v = v | 32'hffff_0000;
            end else begin
                v = w;
            end
        end
        if (!mis && we) begin
            mask = (sz == 0) ? (32'h0000_00ff << sh) : (sz == 1) ? (32'h0000_ffff << sh) : 32'hffff_ffff;
            ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
        end
        lat = (mis || (we && sz == 2)) ? 1 : 2;
        exp_q.push_back(v);
        exp_mis_q.push_back(mis);

        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
        cpu_addr = addr; cpu_wdata = wdata;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (chk && i == 1 && !mis) check("cpu_ram_addr_t1", 32'(ram_addr), idx);
            if (cpu_ack) begin
                got = 1;
                if (chk) check("cpu_latency", i, lat);
                if (we && !mis) begin
                    check("st_ram_we", 32'(ram_we), 1);
                    check("st_ram_wdata", ram_wdata, ref_mem[idx]);
                    check("st_ram_addr", 32'(ram_addr), idx);
                end else if (chk) begin
                    check("ld_or_err_no_we", 32'(ram_we), 0);
                end
                break;
            end
            if (chk) check("no_we_before_ack", 32'(ram_we), 0);
        end
        if (!got) check("cpu_ack_timeout", 0, 1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic ld_write(input logic [31:0] addr, input logic [31:0] data, input bit chk);
        int idx;
        bit got;
        idx = int'(addr[AW+1:2]);
        ref_mem[idx] = data;
        ld_pending++;
        @(posedge clk);
        #1;
        ld_req = 1'b1; ld_addr = addr; ld_wdata = data;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ld_ack) begin
                got = 1;
                if (chk) check("ld_latency", i, 1);
                check("ld_ram_we", 32'(ram_we), 1);
                check("ld_ram_wdata", ram_wdata, data);
                check("ld_ram_addr", 32'(ram_addr), idx);
                break;
            end
        end
        if (!got) check("ld_ack_timeout", 0, 1);
        @(posedge clk);
        #1 ld_req = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_ack) begin
                cpu_ack_cyc <= cyc;
                if (exp_q.size() == 0) begin
                    check("cpu_ack_unexpected", 1, 0);
                end else begin
                    check("cpu_rdata", cpu_rdata, exp_q.pop_front());
                    check("cpu_misalign", 32'(cpu_misalign), 32'(exp_mis_q.pop_front()));
                end
            end else if (cpu_misalign) begin
                check("misalign_without_ack", 32'(cpu_misalign), 0);
            end
            if (ld_ack) begin
                ld_ack_cyc <= cyc;
                check("ld_ack_expected", 32'(ld_pending > 0), 1);
                if (ld_pending > 0) ld_pending--;
            end
            if (cpu_ack && ld_ack) check("dual_ack", 1, 0);
            if (!ram_we) check("wdata_zero_when_idle", ram_wdata, 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] saved;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_ld_ack", 32'(ld_ack), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_misalign", 32'(cpu_misalign), 0);
        check("rst_busy", 32'(busy), 0);
        for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);
        @(posedge clk);
        #1 rst = 1'b0;

        // Tie straight out of reset: CPU first, loader two cycles after cpu_ack.
        fork
            cpu_access(1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 1'b1);
            ld_write(32'h0000_0080, 32'h1234_5678, 1'b0);
        join
        check("arb_loader_after_cpu", ld_ack_cyc - cpu_ack_cyc, 2);
        fork
            cpu_access(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h0BAD_BEEF, 1'b1);
            ld_write(32'h0000_0084, 32'h8765_4321, 1'b0);
        join
        check("arb_second_tie_cpu_first", 32'(cpu_ack_cyc < ld_ack_cyc), 1);

        set_word(4, 32'h8899_AABB);
        cpu_access(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
        set_word(4, 32'h1122_3344);
        cpu_access(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00EE, 1'b1);
        check("sb_ram_contents", mem[4], 32'hEE22_3344);
        set_word(4, 32'h1122_8044);
        cpu_access(1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'd0, 1'b1);
        cpu_access(1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'd0, 1'b1);
        cpu_access(1'b0, 2'd1, 1'b0, 32'h0000_0005, 32'd0, 1'b1);
        cpu_access(1'b1, 2'd2, 1'b0, 32'h0000_0012, 32'h5555_AAAA, 1'b1);
        cpu_access(1'b0, 2'd3, 1'b0, 32'hABCD_0010, 32'd0, 1'b1);
        cpu_access(1'b1, 2'd1, 1'b0, 32'h0000_0016, 32'hFFFF_9ABC, 1'b1);
        cpu_access(1'b0, 2'd1, 1'b0, 32'h0000_0016, 32'd0, 1'b1);
        cpu_access(1'b0, 2'd1, 1'b1, 32'h0000_0016, 32'd0, 1'b1);

        // Reset during the read phase of a halfword store abandons it.
        saved = ref_mem[8];
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'd1; cpu_unsigned = 1'b0;
        cpu_addr = 32'h0000_0022; cpu_wdata = 32'h0000_7777;
        @(posedge clk);
        #1 rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ram_we", 32'(ram_we), 0);
        check("rst_mid_cpu_ack", 32'(cpu_ack), 0);
        repeat (3) @(posedge clk);
        check("rst_mid_ram_unchanged", mem[8], saved);

        // Randomised concurrent traffic: CPU in the low half, loader in the high half.
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    a = $urandom;
                    a[AW+1] = 1'b0;
                    cpu_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 1)), a, $urandom, 1'b0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                for (int n = 0; n < 80; n++) begin
                    logic [31:0] la;
                    la = $urandom;
                    la[AW+1] = 1'b1;
                    la[1:0]  = 2'b00;
                    ld_write(la, $urandom, 1'b0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        join

        repeat (4) @(posedge clk);
        for (int i = 0; i < DEPTH; i++) check("final_mem", mem[i], ref_mem[i]);
        check("exp_queue_drained", exp_q.size(), 0);
        check("ld_pending_drained", ld_pending, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
